// File: rtl/fetch_bram_ffn_intermediate_o_top_if.sv
// Host write port and tile-fetch control/read bus for the FFN intermediate / O activation store.
interface fetch_bram_ffn_intermediate_o_top_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 256
);
  logic                  start_fetch;
  logic                  reset_addr_counter;
  logic [3:0]            Buffer_Select;
  logic                  Tiles_Control;
  logic                  Double_buffering;
  logic                  wea;
  logic                  ena;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic                  fetch_done;
  logic [DATA_WIDTH-1:0] doutb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic                  busy;

  modport master (
    output start_fetch, reset_addr_counter, Buffer_Select, Tiles_Control, Double_buffering,
    output wea, ena, addra, dina,
    input  fetch_done, doutb, addrb, busy
  );

  modport slave (
    input  start_fetch, reset_addr_counter, Buffer_Select, Tiles_Control, Double_buffering,
    input  wea, ena, addra, dina,
    output fetch_done, doutb, addrb, busy
  );
endinterface

// File: rtl/fetch_bram_ffn_intermediate_o_top.sv
// FFN intermediate / O activation store: simple dual-port BRAM with a tile-fetch read-address FSM.
// Optional macro BRAM_OUT_REG_EN adds a doutb output register (2-cycle read latency).
module fetch_bram_ffn_intermediate_o_top #(
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned ORIGINAL_COLUMNS = 768,
  parameter int unsigned ORIGINAL_ROWS    = 512,
  parameter int unsigned NUM_BITS         = 8,
  parameter int unsigned DATA_WIDTH       = 256
) (
  input  logic clk,
  input  logic rst_n,
  fetch_bram_ffn_intermediate_o_top_if.slave bus
);

  localparam int unsigned E      = DATA_WIDTH / NUM_BITS;
  localparam int unsigned RW_FFN = 4 * ORIGINAL_COLUMNS / E;
  localparam int unsigned RW_O   = ORIGINAL_COLUMNS / E;
  localparam int unsigned CW     = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] LEN_FFN_TILE = CW'(RW_FFN * E);
  localparam logic [CW-1:0] LEN_FFN_ROW  = CW'(RW_FFN);
  localparam logic [CW-1:0] LEN_O_TILE   = CW'(RW_O * E);
  localparam logic [CW-1:0] LEN_O_ROW    = CW'(RW_O);
  localparam logic [CW-1:0] LAST_FFN     = CW'(ORIGINAL_ROWS * RW_FFN - 1);
  localparam logic [CW-1:0] LAST_O       = CW'(ORIGINAL_ROWS * RW_O - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  logic [CW-1:0]         ptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  bank_q;
  logic                  sel_o_q;
  logic                  tiles_q;
  logic                  db_q;
  logic [ADDR_WIDTH-1:0] addrb_q;
  logic [DATA_WIDTH-1:0] doutb_q;
`ifdef BRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] rd_q;
`endif

  logic                  sel_valid;
  logic                  sel_o_in;
  logic                  cur_o;
  logic                  accept;
  logic                  issue;
  logic                  finish;
  logic [CW-1:0]         len;
  logic [CW-1:0]         region_last;
  logic [ADDR_WIDTH-1:0] bank_off;

  always_comb begin
    sel_valid = (bus.Buffer_Select == 4'b1100) || (bus.Buffer_Select == 4'b1101);
    sel_o_in  = (bus.Buffer_Select == 4'b1101);
    state_d   = state_q;
    accept    = 1'b0;
    issue     = 1'b0;
    finish    = 1'b0;
    if (sel_o_q) len = tiles_q ? LEN_O_TILE : LEN_O_ROW;
    else         len = tiles_q ? LEN_FFN_TILE : LEN_FFN_ROW;

    if (bus.reset_addr_counter) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_fetch && sel_valid) begin
            state_d = ST_FETCH;
            accept  = 1'b1;
            issue   = 1'b1;
          end
        end
        ST_FETCH: begin
          if (cnt_q == len) begin
`ifdef BRAM_OUT_REG_EN
            state_d = ST_DRAIN;
`else
            state_d = ST_DONE;
`endif
          end else begin
            issue = 1'b1;
          end
        end
        ST_DRAIN: state_d = ST_DONE;
        ST_DONE: begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end
      endcase
    end

    // The first address of a burst is issued on the accepting edge, so wrap uses the incoming select.
    cur_o       = accept ? sel_o_in : sel_o_q;
    region_last = cur_o ? LAST_O : LAST_FFN;
    bank_off    = {bank_q, {(ADDR_WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (bus.ena && bus.wea) mem[bus.addra] <= bus.dina;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      bank_q  <= 1'b0;
      sel_o_q <= 1'b0;
      tiles_q <= 1'b0;
      db_q    <= 1'b0;
      addrb_q <= '0;
      doutb_q <= '0;
`ifdef BRAM_OUT_REG_EN
      rd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef BRAM_OUT_REG_EN
      rd_q    <= mem[addrb_q];
      doutb_q <= rd_q;
`else
      doutb_q <= mem[addrb_q];
`endif
      if (bus.reset_addr_counter) begin
        ptr_q  <= '0;
        cnt_q  <= '0;
        bank_q <= 1'b0;
      end else begin
        if (accept) begin
          sel_o_q <= sel_o_in;
          tiles_q <= bus.Tiles_Control;
          db_q    <= bus.Double_buffering;
        end
        if (issue) begin
          addrb_q <= bank_off + ptr_q[ADDR_WIDTH-1:0];
          ptr_q   <= (ptr_q == region_last) ? '0 : ptr_q + CW'(1);
          cnt_q   <= accept ? CW'(1) : cnt_q + CW'(1);
        end
        if (finish) bank_q <= db_q ? ~bank_q : 1'b0;
      end
    end
  end

  assign bus.addrb      = addrb_q;
  assign bus.doutb      = doutb_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.fetch_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_fetch_bram_ffn_intermediate_o_top.sv
// Randomized bench for fetch_bram_ffn_intermediate_o_top against an address-queue reference model.
module tb_fetch_bram_ffn_intermediate_o_top;
  localparam int AW   = 16;
  localparam int DW   = 256;
  localparam int COLS = 768;
  localparam int ROWS = 512;
  localparam int NB   = 8;
  localparam int E    = DW / NB;
`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_bram_ffn_intermediate_o_top_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_bram_ffn_intermediate_o_top #(
    .ADDR_WIDTH(AW), .ORIGINAL_COLUMNS(COLS), .ORIGINAL_ROWS(ROWS),
    .NUM_BITS(NB), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a burst is expanded into its full address list at the start edge.
  int              aq[$];
  int              m_ptr, m_bank, m_post;
  bit              m_db;
  logic            e_busy, e_done;
  int              e_addrb;
  logic [DW-1:0]   e_dout, e_rd;
  bit              e_known, e_rd_known;
  logic [DW-1:0]   mm [int];

  always @(posedge clk) begin : model
    logic [DW-1:0] rd;
    bit            rk;
    int            rw, len, rg;
    rk = mm.exists(e_addrb);
    rd = rk ? mm[e_addrb] : '0;
    if (LAT == 2) begin
      e_dout = e_rd; e_known = e_rd_known;
      e_rd = rd;     e_rd_known = rk;
    end else begin
      e_dout = rd;   e_known = rk;
    end
    if (bus.ena && bus.wea) mm[int'(bus.addra)] = bus.dina;
    if (!rst_n) begin
      aq.delete(); m_ptr = 0; m_bank = 0; m_post = 0;
      e_busy = 0; e_done = 0; e_addrb = 0;
      e_dout = '0; e_known = 1; e_rd = '0; e_rd_known = 1;
    end else if (bus.reset_addr_counter) begin
      aq.delete(); m_ptr = 0; m_bank = 0; m_post = 0;
      e_busy = 0; e_done = 0;
    end else begin
      if (!e_busy && bus.start_fetch &&
          (bus.Buffer_Select == 4'hC || bus.Buffer_Select == 4'hD)) begin
        rw   = (bus.Buffer_Select == 4'hD) ? COLS / E : 4 * COLS / E;
        len  = bus.Tiles_Control ? rw * E : rw;
        rg   = ROWS * rw;
        m_db = bus.Double_buffering;
        for (int i = 0; i < len; i++) begin
          aq.push_back(((m_bank << (AW - 1)) + m_ptr) % (1 << AW));
          m_ptr = (m_ptr + 1) % rg;
        end
      end
      e_done = 0;
      if (aq.size() > 0) begin
        e_addrb = aq.pop_front();
        e_busy  = 1;
        if (aq.size() == 0) m_post = LAT;
      end else if (m_post > 0) begin
        m_post--;
        e_busy = 1;
        if (m_post == 0) begin
          e_done = 1;
          m_bank = m_db ? 1 - m_bank : 0;
        end
      end else begin
        e_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", DW'(bus.busy), DW'(e_busy));
      chk("fetch_done", DW'(bus.fetch_done), DW'(e_done));
      chk("addrb", DW'(bus.addrb), DW'(e_addrb));
      if (e_known) chk("doutb", bus.doutb, e_dout);
    end
  end

  task automatic rac_pulse(input int n);
    bus.reset_addr_counter = 1'b1;
    repeat (n) @(negedge clk);
    #1 bus.reset_addr_counter = 1'b0;
  endtask

  // Drive one start pulse and follow the burst until busy drops (bounded).
  task automatic fetch(input logic [3:0] sel, input bit tiles, input bit db,
                       input int abort_at, input bit rnd_wr,
                       output int first, output int cycles, output int dones,
                       output logic [DW-1:0] done_dout);
    int c;
    bus.Buffer_Select    = sel;
    bus.Tiles_Control    = tiles;
    bus.Double_buffering = db;
    bus.start_fetch      = 1'b1;
    cycles = 0; dones = 0; done_dout = '0;
    @(negedge clk);
    first = int'(bus.addrb);
    for (c = 0; c < 5000; c++) begin
      if (!bus.busy) break;
      cycles++;
      if (bus.fetch_done) begin
        dones++;
        done_dout = bus.doutb;
      end
      #1;
      bus.start_fetch        = 1'b0;
      bus.reset_addr_counter = (c == abort_at);
      bus.ena   = rnd_wr && ($urandom_range(0, 3) == 0);
      bus.wea   = bus.ena;
      bus.addra = AW'($urandom_range(0, 4095));
      bus.dina  = {8{$urandom()}};
      @(negedge clk);
    end
    #1;
    bus.start_fetch = 1'b0;
    bus.reset_addr_counter = 1'b0;
    bus.ena = 1'b0;
    bus.wea = 1'b0;
    if (c == 5000) chk("fetch_timeout", DW'(1), DW'(0));
  endtask

  initial begin
    int first, cycles, dones;
    logic [DW-1:0] dd;
    logic [3:0] sel;
    bus.start_fetch = 0; bus.reset_addr_counter = 0; bus.Buffer_Select = 4'hC;
    bus.Tiles_Control = 0; bus.Double_buffering = 0;
    bus.wea = 0; bus.ena = 0; bus.addra = '0; bus.dina = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", DW'(bus.busy), DW'(0));
    chk("rst_done", DW'(bus.fetch_done), DW'(0));
    chk("rst_addrb", DW'(bus.addrb), DW'(0));
    chk("rst_doutb", bus.doutb, DW'(0));
    chk_en = 1;
    #1 rst_n = 1'b1;

    for (int i = 0; i < 20000; i++) begin
      bus.ena = 1; bus.wea = 1; bus.addra = AW'(i); bus.dina = DW'(32'h5000 + i);
      @(negedge clk); #1;
    end
    for (int i = 0; i < 64; i++) begin
      bus.ena = 1; bus.wea = 1; bus.addra = AW'(32'h8000 + i); bus.dina = DW'(32'h9000 + i);
      @(negedge clk); #1;
    end
    bus.ena = 0; bus.wea = 0;
    chk("idle_after_writes", DW'(bus.busy), DW'(0));

    fetch(4'hC, 1, 0, -1, 0, first, cycles, dones, dd);
    chk("ffn_tile_first", DW'(first), DW'(0));
    chk("ffn_tile_busy", DW'(cycles), DW'(3072 + LAT));
    chk("ffn_tile_dones", DW'(dones), DW'(1));
    chk("ffn_tile_last", dd, DW'(32'h5BFF));

    rac_pulse(2);
    fetch(4'hD, 1, 0, -1, 0, first, cycles, dones, dd);
    chk("o_tile_first", DW'(first), DW'(0));
    chk("o_tile_dones", DW'(dones), DW'(1));
    chk("o_tile_last", dd, DW'(32'h52FF));

    rac_pulse(1);
    fetch(4'hC, 0, 0, -1, 0, first, cycles, dones, dd);
    chk("row1_last", dd, DW'(32'h505F));
    fetch(4'hC, 0, 0, -1, 0, first, cycles, dones, dd);
    chk("row2_first", DW'(first), DW'(96));
    chk("row2_last", dd, DW'(32'h50BF));

    rac_pulse(1);
    fetch(4'hD, 0, 1, -1, 0, first, cycles, dones, dd);
    chk("db1_first", DW'(first), DW'(0));
    fetch(4'hD, 0, 1, -1, 0, first, cycles, dones, dd);
    chk("db2_first", DW'(first), DW'(32'h8018));
    chk("db2_last", dd, DW'(32'h902F));

    fetch(4'hC, 1, 0, 4, 0, first, cycles, dones, dd);
    chk("abort_busy_cycles", DW'(cycles), DW'(5));
    chk("abort_no_done", DW'(dones), DW'(0));
    fetch(4'hD, 0, 0, -1, 0, first, cycles, dones, dd);
    chk("restart_first", DW'(first), DW'(0));

    fetch(4'h3, 0, 0, -1, 0, first, cycles, dones, dd);
    chk("invalid_sel_ignored", DW'(cycles), DW'(0));

    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 4))
        0, 1:    sel = 4'hC;
        2, 3:    sel = 4'hD;
        default: sel = 4'($urandom_range(0, 11));
      endcase
      if ($urandom_range(0, 4) == 0) rac_pulse(1);
      fetch(sel, (sel == 4'hD) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : -1, 1'b1,
            first, cycles, dones, dd);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      #1;
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
